// File: rtl/writeback_stage.sv
// Final pipeline stage: load alignment/extension, one-entry early-read buffer,
// register-file write port, load stall and retired-instruction counter.
module writeback_stage #(
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             valid_i,
    input  logic [63:0]      rd_data_i,
    input  logic [4:0]       rd_idx_i,
    input  logic             rd_wr_en_i,
    input  logic [2:0]       rd_wr_src_1h_i,
    input  logic [3:0]       mem_width_1h_i,
    input  logic             mem_sign_i,
    input  logic [2:0]       byte_addr_i,
    input  logic [63:0]      dmem_rdata_i,
    input  logic             dmem_rvalid_i,
    output logic             rf_wr_en_ao,
    output logic [4:0]       rf_wr_idx_ao,
    output logic [63:0]      rf_wr_data_ao,
    output logic             load_stall_ao,
    output logic             retire_o,
    output logic [CNT_W-1:0] instret_o
);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    buf_state_e       state_q, state_d;
    logic [63:0]      buf_q, buf_d;
    logic             retire_q, retire_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic        is_load;
    logic        data_ready;
    logic        retire;
    logic [63:0] raw;
    logic [63:0] sh;
    logic [63:0] aligned;
    logic        ext;

    assign is_load    = valid_i & rd_wr_src_1h_i[1];
    assign raw        = (state_q == BUF_FULL) ? buf_q : dmem_rdata_i;
    assign data_ready = ~is_load | (state_q == BUF_FULL) | dmem_rvalid_i;
    assign retire     = valid_i & data_ready & ~stall_i;
    assign sh         = raw >> {byte_addr_i, 3'b000};

    // Buffer only captures a response that arrives while the stage is held;
    // a second response while FULL is dropped so the first one is kept.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        case (state_q)
            BUF_EMPTY: begin
                if (is_load && dmem_rvalid_i && stall_i) begin
                    state_d = BUF_FULL;
                    buf_d   = dmem_rdata_i;
                end
            end
            BUF_FULL: begin
                if (!stall_i) begin
                    state_d = BUF_EMPTY;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_comb begin
        aligned = 64'h0;
        ext     = 1'b0;
        case (mem_width_1h_i)
            4'b0001: begin
                ext     = mem_sign_i & sh[7];
                aligned = {{56{ext}}, sh[7:0]};
            end
            4'b0010: begin
                ext     = mem_sign_i & sh[15];
                aligned = {{48{ext}}, sh[15:0]};
            end
            4'b0100: begin
                ext     = mem_sign_i & sh[31];
                aligned = {{32{ext}}, sh[31:0]};
            end
            4'b1000: aligned = sh;
            default: aligned = 64'h0;
        endcase
    end

    assign rf_wr_data_ao = rd_wr_src_1h_i[1] ? aligned : rd_data_i;
    assign rf_wr_idx_ao  = rd_idx_i;
    // Outputs are forced quiet while reset is asserted.
    assign rf_wr_en_ao   = rst_ni & valid_i & rd_wr_en_i & (rd_idx_i != 5'd0)
                           & data_ready & ~stall_i;
    assign load_stall_ao = rst_ni & is_load & ~data_ready;

    assign retire_d  = retire;
    assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= BUF_EMPTY;
            buf_q     <= 64'h0;
            retire_q  <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            retire_q  <= retire_d;
            instret_q <= instret_d;
        end
    end

    assign retire_o  = retire_q;
    assign instret_o = instret_q;

endmodule
